// File: rtl/dct_transpose_if.sv
// Stream bundle between the row-pass DCT, the transpose buffer and the column-pass DCT.
// Both the row side (in_*) and the column side (out_*) use the same valid/ready handshake.
interface dct_transpose_if #(
  parameter int DATA_W = 16
);
  logic signed [7:0][DATA_W-1:0] in_data;
  logic                          in_valid;
  logic                          in_ready;
  logic signed [7:0][DATA_W-1:0] out_data;
  logic                          out_valid;
  logic                          out_ready;
  logic        [2:0]             out_col;
  logic                          out_last;

  // Transpose buffer side.
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_col, out_last
  );

  // Row-DCT / column-DCT side.
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_col, out_last
  );
endinterface

// File: rtl/dct_transpose.sv
// Ping-pong 8x8 transpose buffer: rows are written into one bank while the
// other bank is read out column by column.
module dct_transpose #(
  parameter int DATA_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  dct_transpose_if.slave bus
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; valid/data never wait on ready, and in_ready / out_valid come
  // from registered state only.

  logic [DATA_W-1:0] bank_mem [2][8][8];
  logic [1:0]        full;
  logic [1:0]        full_nxt;
  logic              wr_bank;
  logic              rd_bank;
  logic [2:0]        wr_row;
  logic [2:0]        rd_col;
  logic              wr_fire;
  logic              rd_fire;

  assign bus.in_ready  = !full[wr_bank];
  assign bus.out_valid = full[rd_bank];
  assign bus.out_col   = rd_col;
  assign bus.out_last  = full[rd_bank] && (rd_col == 3'd7);

  assign wr_fire = bus.in_valid && !full[wr_bank];
  assign rd_fire = full[rd_bank] && bus.out_ready;

  // Writer and reader always address different banks when both fire, so the
  // set and the clear can never collide on the same flag.
  always_comb begin
    full_nxt = full;
    if (wr_fire && (wr_row == 3'd7)) full_nxt[wr_bank] = 1'b1;
    if (rd_fire && (rd_col == 3'd7)) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_row  <= 3'd0;
      rd_col  <= 3'd0;
    end else begin
      full <= full_nxt;
      if (wr_fire) begin
        wr_row <= wr_row + 3'd1;
        if (wr_row == 3'd7) wr_bank <= !wr_bank;
      end
      if (rd_fire) begin
        rd_col <= rd_col + 3'd1;
        if (rd_col == 3'd7) rd_bank <= !rd_bank;
      end
    end
  end

  // Coefficient storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < 8; i++) begin
        bank_mem[wr_bank][wr_row][i] <= bus.in_data[i];
      end
    end
  end

  always_comb begin
    bus.out_data = '0;
    for (int r = 0; r < 8; r++) begin
      bus.out_data[r] = bank_mem[rd_bank][r][rd_col];
    end
  end

endmodule

// File: tb/tb_dct_transpose.sv
// Self-checking bench for dct_transpose: directed latency/backpressure/streaming
// cases plus randomized traffic, checked by a transposing reference model.
module tb_dct_transpose;

  localparam int DATA_W = 16;
  localparam int EXP_W  = 8 * DATA_W + 4;

  typedef logic [7:0][DATA_W-1:0] vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  dct_transpose_if #(.DATA_W(DATA_W)) bus ();

  dct_transpose #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [EXP_W-1:0] exp_q[$];
  vec_t             row_buf[$];
  logic [EXP_W-1:0] e_item;
  bit               rand_ready = 1'b0;
  bit               prev_stall = 1'b0;
  vec_t             prev_data;
  logic [2:0]       prev_col;

  task automatic check(input string name, input logic [EXP_W-1:0] got, input logic [EXP_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_i(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference model: a complete block of rows becomes 8 columns, column c
  // holding element c of every row, with row 0 in element 0.
  task automatic model_block();
    vec_t col;
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < 8; r++) col[r] = row_buf[r][c];
      exp_q.push_back({(c == 7), 3'(c), col});
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      row_buf.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_i("stall_valid", int'(bus.out_valid), 1);
        check("stall_hold", EXP_W'({bus.out_col, bus.out_data}), EXP_W'({prev_col, prev_data}));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL col_unexpected: got column %h expected none", bus.out_data);
        end else begin
          e_item = exp_q.pop_front();
          check("column", {bus.out_last, bus.out_col, bus.out_data}, e_item);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_col   = bus.out_col;
      if (bus.in_valid && bus.in_ready) begin
        row_buf.push_back(bus.in_data);
        if (row_buf.size() == 8) begin
          model_block();
          row_buf.delete();
        end
      end
    end
  end

  // Random downstream backpressure.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) bus.out_ready = ($urandom_range(0, 1) == 1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_row(input vec_t d);
    int cyc = 0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: in_ready stuck at %0d expected 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 7))
        0:       v[i] = 16'h8000;
        1:       v[i] = 16'h7fff;
        default: v[i] = DATA_W'($urandom);
      endcase
    end
    return v;
  endfunction

  task automatic drain(input string name);
    int cyc = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || bus.out_valid) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check_i({name, "_drain_q"}, exp_q.size(), 0);
    check_i({name, "_drain_valid"}, int'(bus.out_valid), 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vec_t v;
    int   accepted;
    int   fires;
    int   cyc;
    int   gaps;
    bit   vb[48];
    bit   rb[48];

    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    idle(2);
    check_i("rst_in_ready", int'(bus.in_ready), 1);
    check_i("rst_out_valid", int'(bus.out_valid), 0);
    check_i("rst_out_col", int'(bus.out_col), 0);
    check_i("rst_out_last", int'(bus.out_last), 0);
    rst_n = 1'b1;
    idle(1);

    // Single block, ramp data, downstream always ready.
    bus.out_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) v[c] = DATA_W'(16 * r + c);
      send_row(v);
      if (r == 6) check_i("lat_before", int'(bus.out_valid), 0);
      if (r == 7) begin
        check_i("lat_after", int'(bus.out_valid), 1);
        check_i("lat_first_col", int'(bus.out_col), 0);
      end
    end
    drain("ramp");

    // Sign extremes.
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) v[c] = (r == 0) ? 16'h8000 : (r == 7) ? 16'h7fff : 16'hffff;
      send_row(v);
    end
    drain("extreme");

    // Backpressure: both banks fill, then writer stalls.
    bus.out_ready = 1'b0;
    accepted = 0;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 24; k++) begin
      bus.in_data = rand_vec();
      @(negedge clk);
      if (bus.in_ready) accepted++;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    check_i("bp_accepted", accepted, 16);
    check_i("bp_in_ready_low", int'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    fires = 0;
    cyc = 0;
    while (fires < 8 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.out_valid) fires++;
    end
    check_i("bp_fires", fires, 8);
    check_i("bp_ready_same_cycle", int'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    check_i("bp_ready_next_cycle", int'(bus.in_ready), 1);
    drain("bp");

    // Full-rate streaming of 4 blocks.
    fork
      begin
        for (int k = 0; k < 32; k++) send_row(rand_vec());
      end
      begin
        for (int k = 0; k < 48; k++) begin
          @(negedge clk);
          vb[k] = bus.out_valid;
          rb[k] = bus.in_ready;
        end
      end
    join
    gaps = 0;
    for (int k = 0; k < 32; k++) if (!rb[k]) gaps++;
    check_i("stream_in_stalls", gaps, 0);
    gaps = 0;
    for (int k = 8; k < 40; k++) if (!vb[k]) gaps++;
    check_i("stream_out_gaps", gaps, 0);
    check_i("stream_valid_c7", int'(vb[7]), 0);
    check_i("stream_valid_c40", int'(vb[40]), 0);
    drain("stream");

    // Random valid/ready over 100 blocks.
    rand_ready = 1'b1;
    for (int b = 0; b < 100; b++) begin
      for (int r = 0; r < 8; r++) begin
        while ($urandom_range(0, 1) == 1) idle(1);
        send_row(rand_vec());
      end
    end
    rand_ready = 1'b0;
    idle(1);
    bus.out_ready = 1'b1;
    drain("random");

    // Reset while block 0 is mid-output and block 1 partially written.
    bus.out_ready = 1'b0;
    for (int r = 0; r < 13; r++) send_row(rand_vec());
    bus.out_ready = 1'b1;
    idle(3);
    #2;
    rst_n = 1'b0;
    #1;
    check_i("mid_rst_out_valid", int'(bus.out_valid), 0);
    check_i("mid_rst_in_ready", int'(bus.in_ready), 1);
    check_i("mid_rst_out_col", int'(bus.out_col), 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    for (int r = 0; r < 8; r++) begin
      send_row(rand_vec());
      if (r == 7) begin
        check_i("post_rst_valid", int'(bus.out_valid), 1);
        check_i("post_rst_col", int'(bus.out_col), 0);
      end
    end
    drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dct_transpose.md
Name: dct_transpose

Overview:
- Ping-pong transpose buffer between the row-pass 1-D 8-point DCT and the column-pass 1-D DCT of the 2-D 8x8 DCT.
- Accepts one 8-coefficient row vector per handshake from the row DCT (combinational, 8 x signed 16-bit).
- After a full 8x8 block is collected, emits the block column by column to the column DCT.
- Two banks allow full-rate streaming: one block is written while the previous block is read.

Parameters:
DATA_W, 16, width of each signed coefficient (row-DCT output width)

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  DATA_W x [7:0] (signed)  row vector; element i = row coefficient i
in_valid  input  1  in_data valid
in_ready  output  1  buffer can accept a row this cycle
out_data  output  DATA_W x [7:0] (signed)  column vector; element r = coefficient from row r
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts column this cycle
out_col  output  3  index of the column currently on out_data
out_last  output  1  high with column 7 of a block

Behaviour:
- Storage: two banks, bank[b][row][col], 8x8 x DATA_W each. Contents are not reset.
- Per-bank state: full[b] flag.
- Write-side state: wr_bank (1 bit), wr_row (3 bits).
- Read-side state: rd_bank (1 bit), rd_col (3 bits).
- Reset (rst_n low, asynchronous):
  - full[0] = full[1] = 0; wr_bank = rd_bank = 0; wr_row = rd_col = 0.
  - Outputs: in_ready = 1, out_valid = 0, out_col = 0, out_last = 0.
  - out_data content is don't-care while out_valid = 0.
- in_ready = !full[wr_bank]. It depends on registered state only; there is no combinational path from out_ready.
- Write handshake (in_valid && in_ready):
  - bank[wr_bank][wr_row][i] <= in_data[i] for i = 0..7.
  - wr_row increments.
  - On wr_row == 7: set full[wr_bank], toggle wr_bank, wr_row wraps to 0.
- out_valid = full[rd_bank].
- out_data[r] = bank[rd_bank][r][rd_col], r = 0..7. Combinational read of registered storage.
- out_col = rd_col; out_last = out_valid && (rd_col == 7).
- Read handshake (out_valid && out_ready):
  - rd_col increments.
  - On rd_col == 7: clear full[rd_bank], toggle rd_bank, rd_col wraps to 0.
- Latency: out_valid rises the cycle after the 8th row of a block is accepted. Column 0 is presented then.
- Throughput:
  - Back-to-back blocks stream with no bubble when in_valid and out_ready are held high.
  - Row 0 of block N+2 is accepted in the cycle after column 7 of block N is accepted.
- Simultaneous events:
  - A write completing a bank and a read freeing the other bank in the same cycle both take effect.
  - A bank being freed while the writer waits on it raises in_ready on the next cycle, not the same cycle.
- Full condition: with both banks full, in_ready = 0 and in_valid is ignored.
- Empty condition: with both banks empty, out_valid = 0 and out_ready is ignored.
- out_data and out_col are held stable while out_valid && !out_ready.
- Data is passed bit-exact: no arithmetic, no saturation. Sign is preserved, including -2^(DATA_W-1).
- Reset mid-block: any partial block and any full banks are discarded. The first row after reset is treated as row 0 of bank 0.

Test Plan:
- Single block, out_ready = 1: send rows r = 0..7 with in_data[c] = 16r + c.
  - out_valid rises the cycle after row 7.
  - Column c has out_data[r] = 16r + c, out_col = c, out_last only at c = 7.
  - Then out_valid = 0.
- Sign/extremes: row 0 = all -32768, row 7 = all 32767, others -1.
  - Every column reads [-32768, -1, -1, -1, -1, -1, -1, 32767] (element 0 first).
- Backpressure: out_ready = 0, stream rows continuously.
  - Exactly 16 rows are accepted, then in_ready = 0.
  - Raise out_ready: after 8 column handshakes, in_ready returns high the next cycle.
  - All 16 columns come out in order.
- Full-rate streaming: 4 blocks, in_valid = out_ready = 1 throughout.
  - No cycle with in_ready = 0 after the first row.
  - out_valid stays continuous from cycle 8 to cycle 39.
  - Data matches per block.
- Random valid/ready toggling (50% each) over 100 blocks with random data.
  - Scoreboard transpose matches exactly; out_data stable during stalls.
- Reset mid-operation: assert rst_n low after 5 rows of block 1 while block 0 is mid-output.
  - Immediately: out_valid = 0, in_ready = 1.
  - A new block sent afterwards emerges intact with out_col starting at 0.
